// File: rtl/nixie_pkg.sv
// rtl/nixie_pkg.sv - shared Nixie clock constants, button indices and FSM state type
package nixie_pkg;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  // 100 MHz system clock: 10 ms debounce, 500 ms repeat delay, 100 ms repeat rate
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int unsigned DEFAULT_REPEAT_DELAY_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_RATE_CYCLES  = 10_000_000;
  localparam logic [NUM_BTNS-1:0] DEFAULT_REPEAT_MASK = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button pins in, debounced levels and pulses out
//
// btn_n     : raw active-low pins (0 = left, 1 = right, 2 = up, 3 = down)
// btn_level : debounced pressed level, active-high
// btn_pulse : one-cycle press / auto-repeat pulses, active-high
// master    : board / bench side driving the pins
// slave     : the conditioner
interface button_conditioner_if;
  import nixie_pkg::*;

  logic [NUM_BTNS-1:0] btn_n;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_pulse;

  modport master (output btn_n, input btn_level, input btn_pulse);
  modport slave  (input btn_n, output btn_level, output btn_pulse);

endinterface

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button: synchroniser, debounce, press/repeat FSM
//
// clk, rst  : system clock, synchronous active-high reset
// btn_n_i   : raw active-low pin, asynchronous to clk
// level_o   : debounced pressed level
// pulse_o   : registered one-cycle press / repeat pulse
module button_channel
  import nixie_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
  parameter bit          REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  btn_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pulse_q, pulse_d;

  logic sync;
  logic rise;
  logic fall;

  assign sync = ~sync2_q;

  // Synchroniser and debounce: any cycle where sync agrees with the level restarts the count
  always_comb begin
    sync1_d  = btn_n_i;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Edges are taken from level_d so the press pulse lands on the same edge as the level
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HELD;
        HELD:    if (REPEAT_EN && (tmr_q == DELAY_LAST)) state_d = REPEAT;
        REPEAT:  state_d = REPEAT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Release takes priority over a repeat pulse due on the same cycle
  always_comb begin
    pulse_d = 1'b0;
    tmr_d   = tmr_q;
    if (fall) begin
      tmr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_d = '0;
          if (rise) pulse_d = 1'b1;
        end
        HELD: begin
          if (REPEAT_EN) begin
            if (tmr_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + TMR_W'(1);
            end
          end
        end
        REPEAT: begin
          if (tmr_q == RATE_LAST) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: tmr_d = '0;
      endcase
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four-button synchronise / debounce / auto-repeat front end
//
// clk, rst : system clock, synchronous active-high reset
// bus      : slave side of button_conditioner_if (btn_n in, btn_level / btn_pulse out)
module button_conditioner
  import nixie_pkg::*;
#(
  parameter int unsigned         DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned         REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int unsigned         REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK         = DEFAULT_REPEAT_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [NUM_BTNS-1:0] level_w;
  logic [NUM_BTNS-1:0] pulse_w;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_EN           (REPEAT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (bus.btn_n[i]),
      .level_o (level_w[i]),
      .pulse_o (pulse_w[i])
    );
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_w;

endmodule
